ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage feeding the decoder: owns the PC, fetches one instruction per trip
//  from a word-addressed instruction memory with variable read latency, and presents
//  Instruction plus the link address opcplus4. It resolves next PC (sequential, branch, j/jal,
//  jr) from control/ALU results that belong to the instruction it is currently presenting.
// PARAMETERS
//  ISA_WIDTH   32            data/PC width
//  ADDR_WIDTH  14            imem word-address width; imem_addr = pc[ADDR_WIDTH+1:2]
//  PC_RESET    32'h0000_0000 PC value after reset
// PORTS
//  clock            in   1           system clock, rising edge
//  reset            in   1           asynchronous, active-low reset
//  imem_req         out  1           one-cycle read request pulse
//  imem_addr        out  ADDR_WIDTH  word address, valid while imem_req=1
//  imem_rvalid      in   1           read data valid (>=1 cycle after imem_req)
//  imem_rdata       in   ISA_WIDTH   instruction word
//  stall            in   1           downstream not ready; hold current instruction
//  Branch           in   1           beq: taken when Zero=1
//  nBranch          in   1           bne: taken when Zero=0
//  Jmp              in   1           j
//  Jal              in   1           jal
//  Jr               in   1           jr
//  Zero             in   1           ALU zero flag
//  Addr_result      in   ISA_WIDTH   branch target from execute
//  Read_data_1      in   ISA_WIDTH   rs value (jr target)
//  Instruction      out  ISA_WIDTH   current instruction to decoder
//  inst_valid       out  1           Instruction valid
//  branch_base_addr out  ISA_WIDTH   pc+4 (comb.), base for branch target calc
//  opcplus4         out  ISA_WIDTH   registered pc+4 of last jal, to decoder link write
// BEHAVIOUR
//  Reset (async, reset=0): pc=PC_RESET, state=S_REQ, Instruction=0, inst_valid=0, imem_req=0,
//   imem_addr=0, opcplus4=0; branch_base_addr=PC_RESET+4. First request on first edge after release.
//  FSM (registered outputs):
//   S_REQ : imem_req<=1, imem_addr<=pc[ADDR_WIDTH+1:2] for exactly one cycle -> S_WAIT.
//   S_WAIT: imem_req=0; on imem_rvalid: Instruction<=imem_rdata, inst_valid<=1 -> S_HOLD;
//           else stay (no timeout).
//   S_HOLD: inst_valid=1, Instruction stable. stall=1: stay, nothing changes.
//           stall=0: pc<=next_pc; if Jal opcplus4<=pc+4; inst_valid<=0 -> S_REQ.
//  Minimum 3 cycles/instruction (REQ, WAIT with rvalid next cycle, HOLD with stall=0).
//  next_pc priority (sampled only in S_HOLD with stall=0):
//   1 Jr -> {Read_data_1[31:2],2'b00}
//   2 Jmp|Jal -> {pc_plus4[31:28], Instruction[25:0], 2'b00}
//   3 (Branch&Zero)|(nBranch&~Zero) -> {Addr_result[31:2],2'b00}
//   4 else pc+4
//   Low two bits of any target forced to 00. pc+4 wraps modulo 2^32.
//  imem_rvalid outside S_WAIT ignored (stale responses after reset dropped).
//  Control inputs ignored outside S_HOLD&~stall. opcplus4 holds until next jal.
//  Reset mid-operation: immediate return to reset state; any in-flight read discarded.
// TESTING
//  T1 reset release, imem returns words at 0,4,8 with 1-cycle latency -> imem_addr 0,1,2,
//     inst_valid every 3rd cycle, Instruction matches, branch_base_addr 4,8,12.
//  T2 stall=1 for 5 cycles in S_HOLD -> Instruction/inst_valid unchanged, no imem_req,
//     pc advances once on release.
//  T3 pc=0x10, Branch=1, Zero=1, Addr_result=0x40 -> next imem_addr=0x10; with Zero=0 -> 0x5;
//     nBranch=1, Zero=0, Addr_result=0x43 -> imem_addr=0x10 (bits forced).
//  T4 pc=0x0000_0020, Instruction=0x0C00_0100 with Jal=1 -> pc=0x400, imem_addr=0x100,
//     opcplus4=0x24; Jr=1 with Read_data_1=0x24 and Jmp=1 both set -> pc=0x24.
//  T5 imem latency 4 cycles and spurious rvalid in S_REQ/S_HOLD -> spurious data never captured.
//  T6 reset asserted in S_WAIT, rvalid arrives after release -> outputs at reset values,
//     late data ignored, fetch restarts at PC_RESET.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port between the fetch stage and the instruction memory.
// One outstanding request at a time; data is returned with a single rvalid pulse.
interface ifetch_unit_if #(
   parameter int ISA_WIDTH  = 32,
   parameter int ADDR_WIDTH = 14
) ();
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_rvalid;
   logic [ISA_WIDTH-1:0]  imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per trip from a variable-latency
// imem and resolves the next PC from the control results of the presented instruction.
//
// state  | meaning
// S_REQ  | issue a one-cycle read request for the word at pc
// S_WAIT | request outstanding, waiting for imem_rvalid
// S_HOLD | instruction presented to decoder until stall drops
module ifetch_unit #(
   parameter int                   ISA_WIDTH  = 32,
   parameter int                   ADDR_WIDTH = 14,
   parameter logic [ISA_WIDTH-1:0] PC_RESET   = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   ifetch_unit_if.master        imem,
   input  logic                 stall,
   input  logic                 Branch,
   input  logic                 nBranch,
   input  logic                 Jmp,
   input  logic                 Jal,
   input  logic                 Jr,
   input  logic                 Zero,
   input  logic [ISA_WIDTH-1:0] Addr_result,
   input  logic [ISA_WIDTH-1:0] Read_data_1,
   output logic [ISA_WIDTH-1:0] Instruction,
   output logic                 inst_valid,
   output logic [ISA_WIDTH-1:0] branch_base_addr,
   output logic [ISA_WIDTH-1:0] opcplus4
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t                state_q, state_d;
   logic [ISA_WIDTH-1:0]  pc_q, pc_d;
   logic [ISA_WIDTH-1:0]  instr_q, instr_d;
   logic [ISA_WIDTH-1:0]  link_q, link_d;
   logic                  valid_q, valid_d;
   logic                  req_q, req_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ISA_WIDTH-1:0]  pc_plus4;
   logic [ISA_WIDTH-1:0]  next_pc;
   logic                  br_taken;
   logic                  unused_bits;

   assign pc_plus4    = pc_q + ISA_WIDTH'(4);
   assign br_taken    = (Branch & Zero) | (nBranch & ~Zero);
   assign unused_bits = ^{Read_data_1[1:0], Addr_result[1:0]};

   // Jr beats j/jal beats conditional branch; every target is word aligned.
   always_comb begin
      next_pc = pc_plus4;
      if (Jr) begin
         next_pc = {Read_data_1[ISA_WIDTH-1:2], 2'b00};
      end else if (Jmp | Jal) begin
         next_pc = {pc_plus4[ISA_WIDTH-1:ISA_WIDTH-4], instr_q[25:0], 2'b00};
      end else if (br_taken) begin
         next_pc = {Addr_result[ISA_WIDTH-1:2], 2'b00};
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      link_d  = link_q;
      valid_d = valid_q;
      req_d   = 1'b0;
      addr_d  = addr_q;
      case (state_q)
         S_REQ: begin
            req_d   = 1'b1;
            addr_d  = pc_q[ADDR_WIDTH+1:2];
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem.imem_rvalid) begin
               instr_d = imem.imem_rdata;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!stall) begin
               pc_d    = next_pc;
               valid_d = 1'b0;
               state_d = S_REQ;
               if (Jal) begin
                  link_d = pc_plus4;
               end
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_REQ;
         pc_q    <= PC_RESET;
         instr_q <= '0;
         link_q  <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         link_q  <= link_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

   assign imem.imem_req    = req_q;
   assign imem.imem_addr   = addr_q;
   assign Instruction      = instr_q;
   assign inst_valid       = valid_q;
   assign opcplus4         = link_q;
   assign branch_base_addr = pc_plus4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural imem with programmable latency and junk rvalid pulses,
// expected fetch addresses/instructions queued at stimulus time and compared on delivery.
module tb_ifetch_unit;
   localparam int AW = 14;

   typedef struct {
      logic [4:0]    ctl;   // {Jr, Jmp, Jal, Branch, nBranch}
      logic          z;
      logic [31:0]   ar;
      logic [31:0]   rd1;
      logic [AW-1:0] ea;
      logic [31:0]   eb;
      logic [31:0]   el;
   } step_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        stall, Branch, nBranch, Jmp, Jal, Jr, Zero;
   logic [31:0] Addr_result, Read_data_1;
   logic [31:0] Instruction, branch_base_addr, opcplus4;
   logic        inst_valid;

   ifetch_unit_if #(.ISA_WIDTH(32), .ADDR_WIDTH(AW)) imem ();

   ifetch_unit #(.ISA_WIDTH(32), .ADDR_WIDTH(AW), .PC_RESET(32'h0)) dut (
      .clock            (clock),
      .reset            (reset),
      .imem             (imem),
      .stall            (stall),
      .Branch           (Branch),
      .nBranch          (nBranch),
      .Jmp              (Jmp),
      .Jal              (Jal),
      .Jr               (Jr),
      .Zero             (Zero),
      .Addr_result      (Addr_result),
      .Read_data_1      (Read_data_1),
      .Instruction      (Instruction),
      .inst_valid       (inst_valid),
      .branch_base_addr (branch_base_addr),
      .opcplus4         (opcplus4)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   int lat = 1;
   bit spur_en = 1'b0;
   int req_cycles = 0;
   logic [AW-1:0] exp_addr_q[$];
   logic [AW-1:0] obs_addr_q[$];
   logic [31:0]   exp_inst_q[$];

   function automatic logic [31:0] inst_at(input logic [AW-1:0] a);
      return (a == 14'h8) ? 32'h0C00_0100 : {8'hC3, 10'h0, a};
   endfunction

   // imem model: sees a request on the negedge it is visible, answers lat negedges later.
   initial begin : responder
      bit            pend;
      int            cnt;
      logic [AW-1:0] paddr;
      pend = 1'b0;
      cnt = 0;
      paddr = '0;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata = '0;
      forever begin
         @(negedge clock);
         imem.imem_rvalid = 1'b0;
         if (!reset) begin
            pend = 1'b0;
         end else if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               imem.imem_rvalid = 1'b1;
               imem.imem_rdata = inst_at(paddr);
               pend = 1'b0;
            end
         end
         if (reset && imem.imem_req) begin
            req_cycles++;
            obs_addr_q.push_back(imem.imem_addr);
            pend = 1'b1;
            cnt = lat;
            paddr = imem.imem_addr;
         end else if (!pend && !imem.imem_rvalid && spur_en) begin
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata = 32'hDEAD_BEEF;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic clear_ctl();
      {Jr, Jmp, Jal, Branch, nBranch} = 5'b0;
      Zero = 1'b0;
      Addr_result = '0;
      Read_data_1 = '0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (inst_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
   endtask

   // Called at a negedge while parked in HOLD with stall=1.
   task automatic advance(input step_t s, output bit ok);
      {Jr, Jmp, Jal, Branch, nBranch} = s.ctl;
      Zero = s.z;
      Addr_result = s.ar;
      Read_data_1 = s.rd1;
      stall = 1'b0;
      exp_addr_q.push_back(s.ea);
      exp_inst_q.push_back(inst_at(s.ea));
      @(negedge clock);
      clear_ctl();
      stall = 1'b1;
      wait_valid(ok);
   endtask

   task automatic test_reset();
      stall = 1'b1;
      clear_ctl();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem.imem_req); end
      total++; if (imem.imem_addr !== 14'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem.imem_addr); end
      total++; if (Instruction !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", Instruction); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
      total++; if (opcplus4 !== 32'h0) begin bad++; $display("FAIL rst_link got=%h want=0", opcplus4); end
      total++; if (branch_base_addr !== 32'h4) begin bad++; $display("FAIL rst_bbase got=%h want=4", branch_base_addr); end
   endtask

   task automatic test_seq();
      bit            ok;
      logic [AW-1:0] got_a, want_a;
      stall = 1'b0;
      lat = 1;
      for (int k = 0; k < 3; k++) begin
         exp_addr_q.push_back(AW'(k));
         exp_inst_q.push_back(inst_at(AW'(k)));
      end
      @(posedge clock);
      #2 reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      total++; if ({imem.imem_req, imem.imem_addr} !== {1'b1, 14'h0}) begin
         bad++; $display("FAIL seq_first_req got=%b/%h want=1/0", imem.imem_req, imem.imem_addr);
      end
      for (int k = 0; k < 3; k++) begin
         wait_valid(ok);
         if (k == 2) stall = 1'b1;
         if (!ok) begin
            total++; bad++; $display("FAIL seq_timeout step=%0d", k);
            exp_addr_q.delete(); exp_inst_q.delete(); obs_addr_q.delete();
            break;
         end
         want_a = exp_addr_q.pop_front();
         got_a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
         total++; if (got_a !== want_a) begin bad++; $display("FAIL seq_addr step=%0d got=%h want=%h", k, got_a, want_a); end
         total++; if (Instruction !== exp_inst_q[0]) begin bad++; $display("FAIL seq_instr step=%0d got=%h want=%h", k, Instruction, exp_inst_q[0]); end
         void'(exp_inst_q.pop_front());
         total++; if (branch_base_addr !== 32'(4 * (k + 1))) begin
            bad++; $display("FAIL seq_bbase step=%0d got=%h want=%h", k, branch_base_addr, 32'(4 * (k + 1)));
         end
         if (k < 2) @(negedge clock);
      end
      total++; if (req_cycles !== 3) begin bad++; $display("FAIL seq_req_pulses got=%0d want=3", req_cycles); end
   endtask

   task automatic test_stall();
      bit            ok;
      step_t         s;
      logic [AW-1:0] got_a, want_a;
      repeat (5) begin
         @(negedge clock);
         total++; if ({inst_valid, imem.imem_req, Instruction} !== {1'b1, 1'b0, inst_at(14'h2)}) begin
            bad++; $display("FAIL stall_hold got=%b/%b/%h want=1/0/%h", inst_valid, imem.imem_req, Instruction, inst_at(14'h2));
         end
      end
      s = '{5'b0, 1'b0, 32'h0, 32'h0, 14'h3, 32'h10, 32'h0};
      advance(s, ok);
      if (!ok) begin
         total++; bad++; $display("FAIL stall_timeout");
         exp_addr_q.delete(); exp_inst_q.delete(); obs_addr_q.delete();
      end else begin
         want_a = exp_addr_q.pop_front();
         got_a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
         total++; if (got_a !== want_a) begin bad++; $display("FAIL stall_addr got=%h want=%h", got_a, want_a); end
         total++; if (Instruction !== exp_inst_q.pop_front()) begin bad++; $display("FAIL stall_instr got=%h", Instruction); end
         total++; if (branch_base_addr !== s.eb) begin bad++; $display("FAIL stall_bbase got=%h want=%h", branch_base_addr, s.eb); end
      end
   endtask

   task automatic test_branch();
      bit            ok;
      logic [AW-1:0] got_a, want_a;
      logic [31:0]   want_i;
      step_t         tbl[7];
      tbl = '{
         '{5'b00000, 1'b0, 32'h0,  32'h0,  14'h4,  32'h14, 32'h0},
         '{5'b00010, 1'b1, 32'h40, 32'h0,  14'h10, 32'h44, 32'h0},
         '{5'b10000, 1'b0, 32'h0,  32'h10, 14'h4,  32'h14, 32'h0},
         '{5'b00010, 1'b0, 32'h40, 32'h0,  14'h5,  32'h18, 32'h0},
         '{5'b10000, 1'b0, 32'h0,  32'h10, 14'h4,  32'h14, 32'h0},
         '{5'b00001, 1'b0, 32'h43, 32'h0,  14'h10, 32'h44, 32'h0},
         '{5'b00001, 1'b1, 32'h80, 32'h0,  14'h11, 32'h48, 32'h0}
      };
      for (int k = 0; k < 7; k++) begin
         advance(tbl[k], ok);
         if (!ok) begin
            total++; bad++; $display("FAIL br_timeout step=%0d", k);
            exp_addr_q.delete(); exp_inst_q.delete(); obs_addr_q.delete();
            break;
         end
         want_a = exp_addr_q.pop_front();
         want_i = exp_inst_q.pop_front();
         got_a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
         total++; if (got_a !== want_a) begin bad++; $display("FAIL br_addr step=%0d got=%h want=%h", k, got_a, want_a); end
         total++; if (Instruction !== want_i) begin bad++; $display("FAIL br_instr step=%0d got=%h want=%h", k, Instruction, want_i); end
         total++; if (branch_base_addr !== tbl[k].eb) begin
            bad++; $display("FAIL br_bbase step=%0d got=%h want=%h", k, branch_base_addr, tbl[k].eb);
         end
      end
   endtask

   task automatic test_jump();
      bit            ok;
      logic [AW-1:0] got_a, want_a;
      logic [31:0]   want_i;
      step_t         tbl[5];
      tbl = '{
         '{5'b10000, 1'b0, 32'h0,  32'h20,        14'h8,    32'h24,  32'h0},
         '{5'b00110, 1'b1, 32'h80, 32'h0,         14'h100,  32'h404, 32'h24},
         '{5'b11000, 1'b0, 32'h0,  32'h24,        14'h9,    32'h28,  32'h24},
         '{5'b10000, 1'b0, 32'h0,  32'hFFFF_FFFF, 14'h3FFF, 32'h0,   32'h24},
         '{5'b00000, 1'b0, 32'h0,  32'h0,         14'h0,    32'h4,   32'h24}
      };
      for (int k = 0; k < 5; k++) begin
         advance(tbl[k], ok);
         if (!ok) begin
            total++; bad++; $display("FAIL jmp_timeout step=%0d", k);
            exp_addr_q.delete(); exp_inst_q.delete(); obs_addr_q.delete();
            break;
         end
         want_a = exp_addr_q.pop_front();
         want_i = exp_inst_q.pop_front();
         got_a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
         total++; if (got_a !== want_a) begin bad++; $display("FAIL jmp_addr step=%0d got=%h want=%h", k, got_a, want_a); end
         total++; if (Instruction !== want_i) begin bad++; $display("FAIL jmp_instr step=%0d got=%h want=%h", k, Instruction, want_i); end
         total++; if (branch_base_addr !== tbl[k].eb) begin
            bad++; $display("FAIL jmp_bbase step=%0d got=%h want=%h", k, branch_base_addr, tbl[k].eb);
         end
         total++; if (opcplus4 !== tbl[k].el) begin
            bad++; $display("FAIL jmp_link step=%0d got=%h want=%h", k, opcplus4, tbl[k].el);
         end
      end
   endtask

   task automatic test_latency();
      bit            ok;
      step_t         s;
      logic [AW-1:0] got_a, want_a;
      logic [31:0]   want_i;
      lat = 4;
      spur_en = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         s = '{5'b0, 1'b0, 32'h0, 32'h0, AW'(k), 32'(4 * k + 4), 32'h24};
         advance(s, ok);
         if (!ok) begin
            total++; bad++; $display("FAIL lat_timeout step=%0d", k);
            exp_addr_q.delete(); exp_inst_q.delete(); obs_addr_q.delete();
            break;
         end
         want_a = exp_addr_q.pop_front();
         want_i = exp_inst_q.pop_front();
         got_a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
         total++; if (got_a !== want_a) begin bad++; $display("FAIL lat_addr step=%0d got=%h want=%h", k, got_a, want_a); end
         total++; if (Instruction !== want_i) begin bad++; $display("FAIL lat_instr step=%0d got=%h want=%h", k, Instruction, want_i); end
      end
      repeat (4) @(negedge clock);
      total++; if ({inst_valid, Instruction} !== {1'b1, inst_at(14'h3)}) begin
         bad++; $display("FAIL lat_hold_spurious got=%b/%h want=1/%h", inst_valid, Instruction, inst_at(14'h3));
      end
      spur_en = 1'b0;
      lat = 2;
   endtask

   task automatic test_reset_mid();
      bit            ok;
      logic [AW-1:0] got_a, want_a;
      exp_addr_q.push_back(14'h4);
      stall = 1'b0;
      @(negedge clock);
      stall = 1'b1;
      @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      spur_en = 1'b1;
      @(negedge clock);
      want_a = exp_addr_q.pop_front();
      got_a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
      total++; if (got_a !== want_a) begin bad++; $display("FAIL mid_inflight_addr got=%h want=%h", got_a, want_a); end
      total++; if ({inst_valid, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b0, 14'h0}) begin
         bad++; $display("FAIL mid_rst_ctl got=%b/%b/%h want=0/0/0", inst_valid, imem.imem_req, imem.imem_addr);
      end
      total++; if ({Instruction, opcplus4, branch_base_addr} !== {32'h0, 32'h0, 32'h4}) begin
         bad++; $display("FAIL mid_rst_data got=%h/%h/%h want=0/0/4", Instruction, opcplus4, branch_base_addr);
      end
      repeat (2) @(negedge clock);
      exp_addr_q.push_back(14'h0);
      exp_inst_q.push_back(inst_at(14'h0));
      @(posedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      wait_valid(ok);
      spur_en = 1'b0;
      if (!ok) begin
         total++; bad++; $display("FAIL mid_timeout");
      end else begin
         want_a = exp_addr_q.pop_front();
         got_a = (obs_addr_q.size() > 0) ? obs_addr_q.pop_front() : 'x;
         total++; if (got_a !== want_a) begin bad++; $display("FAIL mid_restart_addr got=%h want=%h", got_a, want_a); end
         total++; if (Instruction !== exp_inst_q[0]) begin bad++; $display("FAIL mid_restart_instr got=%h want=%h", Instruction, exp_inst_q[0]); end
         total++; if ({opcplus4, branch_base_addr} !== {32'h0, 32'h4}) begin
            bad++; $display("FAIL mid_restart_pc got=%h/%h want=0/4", opcplus4, branch_base_addr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_stall();
      test_branch();
      test_jump();
      test_latency();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
